// File: rtl/l2_pmem_scheduler.sv
// rtl/l2_pmem_scheduler.sv - L2-to-pmem scheduler with a one-line write-back buffer
// Optional macro WB_FORWARD_EN: reads hitting the buffered line are served from it.
module l2_pmem_scheduler #(
    parameter int s_offset    = 5,
    parameter int s_line      = 8 * (2 ** s_offset),
    parameter int DRAIN_DELAY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              l2_read,
    input  logic              l2_write,
    input  logic [31:0]       l2_address,
    input  logic [s_line-1:0] l2_wdata,
    output logic              l2_resp,
    output logic [s_line-1:0] l2_rdata,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [31:0]       pmem_address,
    output logic [s_line-1:0] pmem_wdata,
    input  logic              pmem_resp,
    input  logic [s_line-1:0] pmem_rdata,
    output logic              wb_valid
);
    localparam logic [31:0] LINE_MASK = ~((32'd1 << s_offset) - 32'd1);
    localparam int CW = $clog2(DRAIN_DELAY + 1) + 1;
    localparam logic [CW-1:0] DELAY = CW'(DRAIN_DELAY);

    typedef enum logic [2:0] {IDLE, WACK, READ, DRAIN, FWD} state_t;

    state_t            state;
    logic [31:0]       wb_addr;
    logic [s_line-1:0] wb_data;
    logic [CW-1:0]     idle_cnt;
    logic [31:0]       req_line;
    logic              hit;
    logic              go_capture;
    logic              go_drain;
    logic              go_read;
    logic              go_fwd;

    assign req_line = l2_address & LINE_MASK;
    assign hit      = wb_valid && (req_line == wb_addr);

    // IDLE decision, in priority order: write capture/conflict, read, idle drain
    always_comb begin
        go_capture = 1'b0;
        go_drain   = 1'b0;
        go_read    = 1'b0;
        go_fwd     = 1'b0;
        if (l2_write) begin
            go_capture = !wb_valid || hit;
            go_drain   = wb_valid && !hit;
        end else if (l2_read) begin
            go_read = !hit;
`ifdef WB_FORWARD_EN
            go_fwd = hit;
`else
            go_drain = hit;
`endif
        end else if (wb_valid) begin
            go_drain = idle_cnt >= DELAY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wb_valid     <= 1'b0;
            wb_addr      <= '0;
            wb_data      <= '0;
            idle_cnt     <= '0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    idle_cnt <= '0;
                    if (go_capture) begin
                        wb_addr  <= req_line;
                        wb_data  <= l2_wdata;
                        wb_valid <= 1'b1;
                        state    <= WACK;
                    end else if (go_drain) begin
                        pmem_write   <= 1'b1;
                        pmem_address <= wb_addr;
                        pmem_wdata   <= wb_data;
                        state        <= DRAIN;
                    end else if (go_read) begin
                        pmem_read    <= 1'b1;
                        pmem_address <= req_line;
                        state        <= READ;
                    end else if (go_fwd) begin
                        state <= FWD;
                    end else if (wb_valid) begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                WACK, FWD: state <= IDLE;
                READ: begin
                    if (pmem_resp) begin
                        pmem_read    <= 1'b0;
                        pmem_address <= '0;
                        state        <= IDLE;
                    end
                end
                DRAIN: begin
                    if (pmem_resp) begin
                        pmem_write   <= 1'b0;
                        pmem_address <= '0;
                        pmem_wdata   <= '0;
                        wb_valid     <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read completion is same-cycle with pmem_resp, so the L2 response is decoded from state
    always_comb begin
        l2_resp  = 1'b0;
        l2_rdata = '0;
        case (state)
            WACK: l2_resp = 1'b1;
            FWD: begin
                l2_resp  = 1'b1;
                l2_rdata = wb_data;
            end
            READ: begin
                if (pmem_resp) begin
                    l2_resp  = 1'b1;
                    l2_rdata = pmem_rdata;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_l2_pmem_scheduler.sv
// tb/tb_l2_pmem_scheduler.sv - self-checking bench for l2_pmem_scheduler
// Transaction-level memory/buffer model, per-cycle monitor, randomized traffic.
module tb_l2_pmem_scheduler;
    localparam int DD = 2;
    localparam logic [255:0] DA = {8{32'hAAAA_0001}};
    localparam logic [255:0] DB = {8{32'hBBBB_0002}};
    localparam logic [255:0] DC = {8{32'hCCCC_0003}};
    localparam logic [255:0] DDATA = {8{32'hDDDD_0004}};

    logic         clk;
    logic         rst;
    logic         l2_read;
    logic         l2_write;
    logic [31:0]  l2_address;
    logic [255:0] l2_wdata;
    logic         l2_resp;
    logic [255:0] l2_rdata;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic         pmem_resp;
    logic [255:0] pmem_rdata;
    logic         wb_valid;

    int checks = 0;
    int errors = 0;

    l2_pmem_scheduler #(.s_offset(5), .s_line(256), .DRAIN_DELAY(DD)) dut (
        .clk(clk), .rst(rst),
        .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address),
        .l2_wdata(l2_wdata), .l2_resp(l2_resp), .l2_rdata(l2_rdata),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
        .wb_valid(wb_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic logic [31:0] line_of(input logic [31:0] a);
        return a & 32'hFFFF_FFE0;
    endfunction

    function automatic logic [255:0] init_line(input logic [31:0] a);
        return {8{a ^ 32'h5A5A_0000}};
    endfunction

    // Physical memory seen by the responder, and the model's idea of memory contents
    logic [255:0] phys    [logic [31:0]];
    logic [255:0] ref_mem [logic [31:0]];

    function automatic logic [255:0] phys_get(input logic [31:0] a);
        return phys.exists(a) ? phys[a] : init_line(a);
    endfunction

    function automatic logic [255:0] ref_get(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_line(a);
    endfunction

    // pmem responder with random latency; hold_resp withholds all responses
    bit hold_resp = 1'b0;
    int rsp_wait  = 0;
    initial begin
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            pmem_resp  = 1'b0;
            pmem_rdata = '0;
            if (rst || hold_resp) begin
                rsp_wait = $urandom_range(0, 3);
            end else if (pmem_read || pmem_write) begin
                if (rsp_wait == 0) begin
                    pmem_resp = 1'b1;
                    if (pmem_read) pmem_rdata = phys_get(pmem_address);
                    else phys[pmem_address] = pmem_wdata;
                    rsp_wait = $urandom_range(0, 3);
                end else begin
                    rsp_wait--;
                end
            end
        end
    end

    // Model: buffered line (m_v/m_a/m_d) plus ref_mem
    bit           m_v = 1'b0;
    logic [31:0]  m_a = '0;
    logic [255:0] m_d = '0;
    logic [255:0] exp_rd;
    int           n_pw = 0;
    int           n_pr = 0;
    logic [31:0]  last_pw_addr = '0;
    logic [255:0] last_pw_data = '0;
    logic [255:0] last_rdata = '0;
    bit           prev_rd = 1'b0, prev_wr = 1'b0, prev_resp = 1'b0, prev_rst = 1'b1;
    logic [31:0]  prev_addr = '0;
    logic [255:0] prev_wdata = '0;

    always @(negedge clk) begin
        if (rst) begin
            m_v = 1'b0;
        end else begin
            if (l2_resp) begin
                if (l2_write) begin
                    chk("wr_ack_conflict", 256'(m_v && (m_a != line_of(l2_address))), 256'(0));
                    m_v = 1'b1;
                    m_a = line_of(l2_address);
                    m_d = l2_wdata;
                end else if (l2_read) begin
                    exp_rd = (m_v && (m_a == line_of(l2_address))) ? m_d : ref_get(line_of(l2_address));
                    chk("rd_data", l2_rdata, exp_rd);
                    last_rdata = l2_rdata;
                end else begin
                    chk("spurious_resp", 256'(1), 256'(0));
                end
            end else begin
                chk("rdata_idle_zero", l2_rdata, 256'(0));
            end
            chk("wb_valid", 256'(wb_valid), 256'(m_v));
            chk("pmem_rd_wr_excl", 256'(pmem_read && pmem_write), 256'(0));
            if ((prev_rd || prev_wr) && !prev_rst) begin
                if (prev_resp) begin
                    chk("pmem_drop", 256'({pmem_read, pmem_write}), 256'(0));
                end else begin
                    chk("pmem_hold", 256'({pmem_read, pmem_write, pmem_address}),
                        256'({prev_rd, prev_wr, prev_addr}));
                    chk("pmem_hold_wdata", pmem_wdata, prev_wdata);
                end
            end
            if (pmem_read && !prev_rd)
                chk("pmem_rd_addr", 256'(pmem_address),
                    256'(l2_read ? line_of(l2_address) : 32'hFFFF_FFFF));
            if (pmem_resp && pmem_write) begin
                chk("drain_addr", 256'(pmem_address), 256'(m_v ? m_a : 32'hFFFF_FFFF));
                chk("drain_data", pmem_wdata, m_d);
                ref_mem[m_a] = m_d;
                m_v = 1'b0;
                n_pw++;
                last_pw_addr = pmem_address;
                last_pw_data = pmem_wdata;
            end
            if (pmem_resp && pmem_read) n_pr++;
        end
        prev_rd    = pmem_read;
        prev_wr    = pmem_write;
        prev_resp  = pmem_resp;
        prev_addr  = pmem_address;
        prev_wdata = pmem_wdata;
        prev_rst   = rst;
    end

    // Called at posedge+1; returns at posedge+1 after dropping the request
    task automatic do_req(input bit wr, input logic [31:0] a, input logic [255:0] d, output int lat);
        l2_write   = wr;
        l2_read    = !wr;
        l2_address = a;
        l2_wdata   = wr ? d : 256'(0);
        lat = 0;
        while (1) begin
            @(negedge clk);
            if (l2_resp) break;
            lat++;
            if (lat > 300) begin
                chk("req_timeout", 256'(0), 256'(1));
                break;
            end
        end
        @(posedge clk);
        #1;
        l2_write   = 1'b0;
        l2_read    = 1'b0;
        l2_address = '0;
        l2_wdata   = '0;
    endtask

    task automatic wait_wb_empty(input string name);
        int n;
        n = 0;
        while (wb_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(name, 256'(wb_valid), 256'(0));
        @(posedge clk);
        #1;
    endtask

    int lat, cnt, pw0, pr0, gap;
    logic [31:0]  ra;
    logic [255:0] rd_data;
    bit rw;

    initial begin
        rst = 1'b1; l2_read = 1'b0; l2_write = 1'b0; l2_address = '0; l2_wdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_outputs", 256'({l2_resp, pmem_read, pmem_write, wb_valid, pmem_address}), 256'(0));
        chk("rst_wdata", pmem_wdata, 256'(0));
        chk("rst_rdata", l2_rdata, 256'(0));
        @(posedge clk);
        #1;

        // Write on empty buffer, then idle drain after DD free cycles
        pw0 = n_pw; pr0 = n_pr;
        do_req(1'b1, 32'h0000_1040, DA, lat);
        chk("wr_latency", 256'(lat), 256'(1));
        chk("wr_no_pmem", 256'({n_pw, n_pr}), 256'({pw0, pr0}));
        chk("wr_wb_valid", 256'(wb_valid), 256'(1));
        cnt = 0;
        while (!pmem_write && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        chk("drain_start_cycles", 256'(cnt), 256'(4));
        chk("drain_addr_lit", 256'(pmem_address), 256'(32'h0000_1040));
        chk("drain_data_lit", pmem_wdata, DA);
        @(posedge clk);
        #1;
        wait_wb_empty("drain_done");
        chk("drain_count", 256'(n_pw), 256'(pw0 + 1));

        // Read bypasses the buffered write
        do_req(1'b1, 32'h0000_1040, DA, lat);
        pw0 = n_pw; pr0 = n_pr;
        do_req(1'b0, 32'h0000_2000, '0, lat);
        chk("bypass_no_drain", 256'(n_pw), 256'(pw0));
        chk("bypass_reads", 256'(n_pr), 256'(pr0 + 1));
        chk("bypass_rdata", last_rdata, init_line(32'h0000_2000));
        chk("bypass_wb_kept", 256'(wb_valid), 256'(1));
        wait_wb_empty("bypass_drain");
        chk("bypass_late_drain", 256'(last_pw_addr), 256'(32'h0000_1040));

        // Coalescing write, then a conflicting write forcing a drain
        do_req(1'b1, 32'h0000_1040, DA, lat);
        pw0 = n_pw;
        do_req(1'b1, 32'h0000_1050, DC, lat);
        chk("coalesce_latency", 256'(lat), 256'(1));
        chk("coalesce_no_pmem", 256'(n_pw), 256'(pw0));
        do_req(1'b1, 32'h0000_3000, DB, lat);
        chk("conflict_drain", 256'(n_pw), 256'(pw0 + 1));
        chk("conflict_drain_addr", 256'(last_pw_addr), 256'(32'h0000_1040));
        chk("conflict_drain_data", last_pw_data, DC);
        chk("conflict_latency", 256'(lat > 1), 256'(1));

        // Read matching the buffered line
        pw0 = n_pw; pr0 = n_pr;
        do_req(1'b0, 32'h0000_3004, '0, lat);
        chk("match_rdata", last_rdata, DB);
`ifdef WB_FORWARD_EN
        chk("fwd_latency", 256'(lat), 256'(1));
        chk("fwd_no_pmem", 256'({n_pw, n_pr}), 256'({pw0, pr0}));
        chk("fwd_wb_kept", 256'(wb_valid), 256'(1));
        wait_wb_empty("fwd_drain");
`else
        chk("match_drain_then_read", 256'({n_pw, n_pr}), 256'({pw0 + 1, pr0 + 1}));
        chk("match_drain_addr", 256'(last_pw_addr), 256'(32'h0000_3000));
        chk("match_wb_empty", 256'(wb_valid), 256'(0));
`endif

        // Reset while a drain waits on pmem
        hold_resp = 1'b1;
        pw0 = n_pw;
        do_req(1'b1, 32'h0000_5000, DDATA, lat);
        cnt = 0;
        while (!pmem_write && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        chk("held_drain_started", 256'(pmem_write), 256'(1));
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_drain", 256'({pmem_write, pmem_read, wb_valid, l2_resp}), 256'(0));
        chk("rst_mid_addr", 256'(pmem_address), 256'(0));
        @(posedge clk);
        #1 hold_resp = 1'b0;
        do_req(1'b0, 32'h0000_5000, '0, lat);
        chk("post_rst_rdata", last_rdata, init_line(32'h0000_5000));
        chk("post_rst_no_write", 256'(n_pw), 256'(pw0));

        // Randomized traffic over a few lines
        for (int i = 0; i < 250; i++) begin
            ra = 32'h0000_8000 + (32'($urandom_range(0, 3)) << 5) + (32'($urandom_range(0, 7)) << 2);
            rw = 1'($urandom_range(0, 1));
            for (int k = 0; k < 8; k++) rd_data[k*32 +: 32] = $urandom;
            do_req(rw, ra, rd_data, lat);
            gap = $urandom_range(0, 5);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
        wait_wb_empty("final_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
